// File: rtl/serial_pkg.sv
// Shared definitions for the pulse-width serial line (receiver and transmitter).
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_GAP   = 3'd2,
        ST_BIT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LONGBIT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/serial_sync_edge.sv
// Synchronizes the serial line into clk and flags active-level edges.
// `pol` is the idle level; act/rise/fall are expressed relative to it.
module serial_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic y,
    input  logic pol,
    output logic act,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   line_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], y};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Previous level is kept raw so a polarity update never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b1}};
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];
    assign act    = line_s ^ pol;
    assign rise   = (line_s != prev_q) & act;
    assign fall   = (line_s != prev_q) & ~act;

endmodule

// File: rtl/serial_rx.sv
// Pulse-width serial receiver: start marker, width-coded bits, valid/ack handoff.
// Bits arrive MSB-first and are committed right-aligned in `data`.
module serial_rx
    import serial_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 256,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              y,
    input  logic              y0,
    input  logic [7:0]        nbits,
    input  logic [CNT_W-1:0]  th_start,
    input  logic [CNT_W-1:0]  th_one,
    input  logic [CNT_W-1:0]  gap_max,
    input  logic              ack,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int BC_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    w_q, w_d;
    logic [CNT_W-1:0]    g_q, g_d;
    logic [BC_W-1:0]     bc_q, bc_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                y0_q, y0_d;

    logic                pol_s, act_s, rise_s, fall_s;
    logic [CNT_W-1:0]    ths_s;
    logic [CNT_W-1:0]    g_inc_s;
    logic [BC_W-1:0]     nb_eff_s;
    logic [BC_W-1:0]     bc_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The frame polarity is frozen once the start marker is seen.
    assign pol_s = (state_q == ST_IDLE) ? y0 : y0_q;

    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .y    (y),
        .pol  (pol_s),
        .act  (act_s),
        .rise (rise_s),
        .fall (fall_s)
    );

    assign ths_s    = (th_start == {CNT_W{1'b0}}) ? CNT_W'(1) : th_start;
    assign g_inc_s  = sat_inc(g_q);
    assign bc_inc_s = bc_q + BC_W'(1);
    assign nb_eff_s = (int'(nbits) > DATA_W) ? BC_W'(DATA_W) : BC_W'(nbits);

    // Next-state logic for the frame FSM, counters and host handshake.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        g_d     = g_q;
        bc_d    = bc_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        code_d  = code_q;
        y0_d    = y0_q;

        if (valid_q && ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                y0_d = y0;
                if (rise_s) begin
                    state_d = ST_START;
                    w_d     = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (fall_s) begin
                    if (w_q >= ths_s) begin
                        state_d = (nb_eff_s == {BC_W{1'b0}}) ? ST_DONE : ST_GAP;
                        g_d     = CNT_W'(1);
                        bc_d    = {BC_W{1'b0}};
                        sh_d    = {DATA_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (act_s) begin
                    w_d = sat_inc(w_q);
                end else begin
                    w_d = w_q;
                end
            end
            ST_GAP: begin
                if (rise_s) begin
                    state_d = ST_BIT;
                    w_d     = CNT_W'(1);
                end else if (g_inc_s > gap_max) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    g_d = g_inc_s;
                end
            end
            ST_BIT: begin
                if (fall_s) begin
                    g_d = CNT_W'(1);
                    if (w_q >= ths_s) begin
                        // An overlong pulse restarts the frame as a fresh marker.
                        state_d = ST_GAP;
                        err_d   = 1'b1;
                        code_d  = ERR_LONGBIT;
                        bc_d    = {BC_W{1'b0}};
                        sh_d    = {DATA_W{1'b0}};
                    end else begin
                        sh_d    = {sh_q[DATA_W-2:0], (w_q >= th_one)};
                        bc_d    = bc_inc_s;
                        state_d = (bc_inc_s == nb_eff_s) ? ST_DONE : ST_GAP;
                    end
                end else if (act_s) begin
                    w_d = sat_inc(w_q);
                end else begin
                    w_d = w_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (valid_q && !ack) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end else begin
                    data_d  = sh_q;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= {CNT_W{1'b0}};
            g_q     <= {CNT_W{1'b0}};
            bc_q    <= {BC_W{1'b0}};
            sh_q    <= {DATA_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            y0_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            g_q     <= g_d;
            bc_q    <= bc_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            y0_q    <= y0_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: table of frames plus hand-written corner sequences.
module tb_serial_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic         y;
    logic         y0;
    logic [7:0]   nbits;
    logic [31:0]  th_start;
    logic [31:0]  th_one;
    logic [31:0]  gap_max;
    logic         ack;
    logic [255:0] data;
    logic         valid;
    logic         err;
    logic [1:0]   err_code;

    int total = 0;
    int bad = 0;
    int err_pulses = 0;
    logic [1:0] last_code = 2'd0;

    typedef struct {
        logic [15:0]  word;
        int           nb;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[7];

    serial_rx dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y0       (y0),
        .nbits    (nbits),
        .th_start (th_start),
        .th_one   (th_one),
        .gap_max  (gap_max),
        .ack      (ack),
        .data     (data),
        .valid    (valid),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (err) begin
            err_pulses++;
            last_code = err_code;
        end
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int n_act, input int n_idle);
        y = ~y0;
        repeat (n_act) tick();
        y = y0;
        repeat (n_idle) tick();
    endtask

    // Bits nb-1..0 of word; 1 = 4 cycles, 0 = 2 cycles; last bit followed by `tail` idle cycles.
    task automatic send_bits(input logic [15:0] word, input int nb, input int tail);
        for (int i = nb - 1; i >= 0; i--) begin
            pulse(word[i] ? 4 : 2, (i == 0) ? tail : 2);
        end
    endtask

    task automatic send_frame(input logic [15:0] word, input int nb, input int tail);
        nbits = 8'(nb);
        if (nb == 0) begin
            pulse(10, tail);
        end else begin
            pulse(10, 2);
            send_bits(word, nb, tail);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int e0;
        int first;

        vecs[0] = '{16'h5aaa, 16, 256'h5aaa};
        vecs[1] = '{16'h00a5, 8,  256'ha5};
        vecs[2] = '{16'h0001, 1,  256'h1};
        vecs[3] = '{16'hffff, 0,  256'h0};
        vecs[4] = '{16'hffff, 16, 256'hffff};
        vecs[5] = '{16'h0005, 3,  256'h5};
        vecs[6] = '{16'hf123, 12, 256'h123};

        rst = 1'b1; y = 1'b1; y0 = 1'b1; nbits = 8'd16;
        th_start = 32'd8; th_one = 32'd3; gap_max = 32'd10; ack = 1'b0;
        repeat (3) tick();
        check("reset_data", data, 256'h0);
        check("reset_valid", 256'(valid), 256'h0);
        check("reset_err", 256'(err), 256'h0);
        check("reset_code", 256'(err_code), 256'h0);
        rst = 1'b0;
        repeat (4) tick();

        // Table of frames, each acknowledged before the next.
        for (int v = 0; v < 7; v++) begin
            e0 = err_pulses;
            send_frame(vecs[v].word, vecs[v].nb, 6);
            check($sformatf("vec%0d_valid", v), 256'(valid), 256'h1);
            check($sformatf("vec%0d_data", v), data, vecs[v].exp);
            check($sformatf("vec%0d_noerr", v), 256'(err_pulses - e0), 256'h0);
            do_ack();
            tick();
            check($sformatf("vec%0d_ackclr", v), 256'(valid), 256'h0);
        end

        // Glitch shorter than the start threshold, stray ack, then a good frame with latency check.
        e0 = err_pulses;
        pulse(3, 12);
        do_ack();
        tick();
        check("glitch_valid", 256'(valid), 256'h0);
        check("glitch_noerr", 256'(err_pulses - e0), 256'h0);
        send_frame(16'h5aaa, 16, 3);
        check("latency_before", 256'(valid), 256'h0);
        tick();
        check("latency_at", 256'(valid), 256'h1);
        check("glitch_next_data", data, 256'h5aaa);
        do_ack();
        tick();

        // Timeout: start + 5 bits then a long idle; error expected on idle cycle 11 + 2 sync stages.
        e0 = err_pulses;
        nbits = 8'd16;
        pulse(10, 2);
        send_bits(16'h5aaa >> 11, 5, 0);
        first = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (err && first == 0) first = t;
        end
        check("timeout_cycle", 256'(first), 256'd13);
        check("timeout_count", 256'(err_pulses - e0), 256'h1);
        check("timeout_code", 256'(err_code), 256'h1);
        check("timeout_valid", 256'(valid), 256'h0);
        send_frame(16'h1234, 16, 6);
        check("timeout_next_data", data, 256'h1234);
        check("timeout_next_valid", 256'(valid), 256'h1);
        do_ack();
        tick();

        // Overrun: second frame without ack is dropped.
        e0 = err_pulses;
        send_frame(16'h5aaa, 16, 6);
        send_frame(16'h1234, 16, 6);
        check("overrun_data", data, 256'h5aaa);
        check("overrun_valid", 256'(valid), 256'h1);
        check("overrun_count", 256'(err_pulses - e0), 256'h1);
        check("overrun_code", 256'(last_code), 256'h3);
        do_ack();
        tick();

        // Ack coincident with the second commit: new frame accepted.
        send_frame(16'h5aaa, 16, 6);
        e0 = err_pulses;
        send_frame(16'h1234, 16, 3);
        check("coinc_pre_data", data, 256'h5aaa);
        do_ack();
        repeat (3) tick();
        check("coinc_data", data, 256'h1234);
        check("coinc_valid", 256'(valid), 256'h1);
        check("coinc_noerr", 256'(err_pulses - e0), 256'h0);
        do_ack();
        tick();

        // Overlong 12-cycle pulse after 4 bits restarts the frame.
        e0 = err_pulses;
        nbits = 8'd16;
        pulse(10, 2);
        send_bits(16'h5aaa >> 12, 4, 2);
        pulse(12, 2);
        send_bits(16'h5aaa, 16, 6);
        check("longbit_count", 256'(err_pulses - e0), 256'h1);
        check("longbit_code", 256'(err_code), 256'h2);
        check("longbit_data", data, 256'h5aaa);
        check("longbit_valid", 256'(valid), 256'h1);

        // Reset in the middle of bit 7 with valid still held.
        e0 = err_pulses;
        pulse(10, 2);
        send_bits(16'h1234 >> 10, 6, 2);
        y = ~y0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_data", data, 256'h0);
        check("midrst_valid", 256'(valid), 256'h0);
        check("midrst_err", 256'(err), 256'h0);
        check("midrst_code", 256'(err_code), 256'h0);
        y0 = 1'b0;
        y = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        send_frame(16'h5aaa, 16, 6);
        check("inv_data", data, 256'h5aaa);
        check("inv_valid", 256'(valid), 256'h1);
        check("inv_noerr", 256'(err_pulses - e0), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
